// File: rtl/password_entry_pkg.sv
// password_entry_pkg: shared state encoding, timing defaults and digit width for the entry keypad
package password_entry_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 64;
  localparam int DIGIT_W             = 2;
  typedef enum logic [1:0] {IDLE, GET_D1, GET_D2, HOLD} state_t;
endpackage

// File: rtl/password_entry_key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and rising press-event generator for the keypad
module key_debounce
  import password_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int W               = DIGIT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_key,
  input  logic [W-1:0] i_code,
  output logic         o_press,
  output logic [W-1:0] o_code
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic          r_key_s1, r_key_s2, r_lvl;
  logic [W-1:0]  r_code_s1, r_code_s2;
  logic [CW-1:0] r_cnt;
  logic          w_flip;
  // The level flips on the edge that completes the stable run, so the event is seen by the FSM on that same edge
  assign w_flip  = (r_key_s2 != r_lvl) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_press = w_flip && r_key_s2;
  assign o_code  = r_code_s2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_s1  <= 1'b0;
      r_key_s2  <= 1'b0;
      r_code_s1 <= '0;
      r_code_s2 <= '0;
      r_lvl     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_key_s1  <= i_key;
      r_key_s2  <= r_key_s1;
      r_code_s1 <= i_code;
      r_code_s2 <= r_code_s1;
      r_lvl     <= w_flip ? r_key_s2 : r_lvl;
      r_cnt     <= (r_key_s2 == r_lvl || w_flip) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/password_entry.sv
// password_entry: two-digit keypad entry FSM with debounced key path, inter-digit timeout and registered outputs
module password_entry
  import password_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sensor_entrance,
  input  logic               key_press,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_clear,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               pass_ready,
  output logic [1:0]         digit_cnt,
  output logic               entry_error
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
  state_t             r_state;
  logic [TW-1:0]      r_to;
  logic [DIGIT_W-1:0] r_d1;
  logic               w_press;
  logic [DIGIT_W-1:0] w_code;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(DIGIT_W)) u_key_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key   (key_press),
    .i_code  (key_code),
    .o_press (w_press),
    .o_code  (w_code)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_to        <= '0;
      r_d1        <= '0;
      password_1  <= '0;
      password_2  <= '0;
      pass_ready  <= 1'b0;
      digit_cnt   <= 2'd0;
      entry_error <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      r_to        <= (r_to == TO_MAX) ? r_to : r_to + 1'b1;
      case (r_state)
        IDLE: if (sensor_entrance) begin
          r_state <= GET_D1;
          r_to    <= '0;
        end
        GET_D1, GET_D2: if (key_clear) begin
          r_state   <= GET_D1;
          r_d1      <= '0;
          digit_cnt <= 2'd0;
          r_to      <= '0;
        end else if (w_press) begin
          r_to <= '0;
          if (r_state == GET_D1) begin
            r_d1      <= w_code;
            digit_cnt <= 2'd1;
            r_state   <= GET_D2;
          end else begin
            password_1 <= r_d1;
            password_2 <= w_code;
            pass_ready <= 1'b1;
            digit_cnt  <= 2'd2;
            r_state    <= HOLD;
          end
        end else if (r_to == TO_MAX) begin
          r_state     <= IDLE;
          r_d1        <= '0;
          digit_cnt   <= 2'd0;
          entry_error <= 1'b1;
        end
        HOLD: if (key_clear) begin
          r_state    <= IDLE;
          r_d1       <= '0;
          r_to       <= '0;
          password_1 <= '0;
          password_2 <= '0;
          pass_ready <= 1'b0;
          digit_cnt  <= 2'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_password_entry.sv
// tb_password_entry: table-driven entry vectors plus scoreboarded password checks and multi-cycle corner sequences
module tb_password_entry;
  import password_entry_pkg::*;
  typedef struct {
    logic [1:0] c1, c2, e1, e2;
  } vec_t;
  typedef struct {
    logic [1:0] p1, p2;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_entrance = 1'b0;
  logic       key_press = 1'b0;
  logic [1:0] key_code = 2'b00;
  logic       key_clear = 1'b0;
  logic [1:0] password_1, password_2, digit_cnt;
  logic       pass_ready, entry_error;
  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  vec_t       tbl[4];
  logic       prev_ready = 1'b0;
  password_entry dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .key_press       (key_press),
    .key_code        (key_code),
    .key_clear       (key_clear),
    .password_1      (password_1),
    .password_2      (password_2),
    .pass_ready      (pass_ready),
    .digit_cnt       (digit_cnt),
    .entry_error     (entry_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic arm();
    sensor_entrance = 1'b1;
    step();
    sensor_entrance = 1'b0;
  endtask
  // Holds the key for hold cycles, then releases for 10; lat is the edge count at which digit_cnt moved, or -1
  task automatic press(input logic [1:0] code, input int hold, output int lat);
    logic [1:0] start;
    start = digit_cnt;
    lat = -1;
    key_code = code;
    key_press = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (lat < 0 && digit_cnt !== start) lat = i;
    end
    key_press = 1'b0;
    repeat (10) step();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (pass_ready === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: pass_ready rose with p1=%0d p2=%0d and nothing expected", password_1, password_2);
      end else begin
        e = sb.pop_front();
        check("sb_p1", password_1, e.p1);
        check("sb_p2", password_2, e.p2);
      end
    end
    prev_ready = pass_ready;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, first, hi;
    tbl[0] = '{2'b01, 2'b10, 2'b01, 2'b10};
    tbl[1] = '{2'b11, 2'b00, 2'b11, 2'b00};
    tbl[2] = '{2'b00, 2'b11, 2'b00, 2'b11};
    tbl[3] = '{2'b10, 2'b01, 2'b10, 2'b01};
    repeat (3) step();
    check("rst_p1", password_1, 0);
    check("rst_p2", password_2, 0);
    check("rst_ready", pass_ready, 0);
    check("rst_cnt", digit_cnt, 0);
    check("rst_err", entry_error, 0);
    reset_n = 1'b1;
    step();
    press(2'b11, 10, lat);
    check("idle_ignore_lat", lat, -1);
    check("idle_ignore_cnt", digit_cnt, 0);
    for (int v = 0; v < 4; v++) begin
      arm();
      check("arm_state", dut.r_state, GET_D1);
      press(tbl[v].c1, 10, lat);
      check("d1_lat", lat, 6);
      check("d1_cnt", digit_cnt, 1);
      check("d1_ready", pass_ready, 0);
      check("d1_p1", password_1, 0);
      sb.push_back('{tbl[v].e1, tbl[v].e2});
      press(tbl[v].c2, 10, lat);
      check("d2_lat", lat, 6);
      check("d2_cnt", digit_cnt, 2);
      check("d2_ready", pass_ready, 1);
      check("d2_p1", password_1, tbl[v].e1);
      check("d2_p2", password_2, tbl[v].e2);
      press(~tbl[v].c2, 10, lat);
      check("hold_ignore_p1", password_1, tbl[v].e1);
      check("hold_ignore_p2", password_2, tbl[v].e2);
      check("hold_ignore_cnt", digit_cnt, 2);
      key_clear = 1'b1;
      step();
      key_clear = 1'b0;
      check("clr_state", dut.r_state, IDLE);
      check("clr_ready", pass_ready, 0);
      check("clr_p1", password_1, 0);
      check("clr_p2", password_2, 0);
      check("clr_cnt", digit_cnt, 0);
    end
    arm();
    key_code = 2'b01;
    key_press = 1'b1;
    repeat (2) step();
    key_press = 1'b0;
    repeat (10) step();
    check("glitch_cnt", digit_cnt, 0);
    check("glitch_state", dut.r_state, GET_D1);
    press(2'b01, 10, lat);
    check("to_d1_lat", lat, 6);
    first = -1;
    hi = 0;
    for (int i = 15; i <= 120; i++) begin
      step();
      if (entry_error === 1'b1) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    check("to_first", first, 64);
    check("to_width", hi, 1);
    check("to_state", dut.r_state, IDLE);
    check("to_cnt", digit_cnt, 0);
    check("to_p1", password_1, 0);
    check("to_p2", password_2, 0);
    arm();
    press(2'b01, 10, lat);
    check("cp_d1_cnt", digit_cnt, 1);
    key_code = 2'b11;
    key_press = 1'b1;
    repeat (5) step();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    check("cp_cnt", digit_cnt, 0);
    check("cp_state", dut.r_state, GET_D1);
    check("cp_ready", pass_ready, 0);
    repeat (4) step();
    key_press = 1'b0;
    repeat (10) step();
    check("cp_after_cnt", digit_cnt, 0);
    sb.push_back('{2'b10, 2'b11});
    press(2'b10, 10, lat);
    check("cp_redo_lat", lat, 6);
    press(2'b11, 10, lat);
    check("cp_redo_ready", pass_ready, 1);
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    arm();
    press(2'b01, 10, lat);
    sb.push_back('{2'b01, 2'b10});
    press(2'b10, 10, lat);
    check("rs_pre_ready", pass_ready, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rs_async_ready", pass_ready, 0);
    check("rs_async_p1", password_1, 0);
    check("rs_async_p2", password_2, 0);
    check("rs_async_cnt", digit_cnt, 0);
    step();
    reset_n = 1'b1;
    step();
    press(2'b11, 10, lat);
    check("rs_post_lat", lat, -1);
    check("rs_post_cnt", digit_cnt, 0);
    check("rs_post_state", dut.r_state, IDLE);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
